alu_ctrl_mdu: RTL and testbench
===============================

// Module: alu_ctrl_mdu
// PURPOSE
//  Parametrised ALU-control successor for the RV32 datapath: decodes ALUOp/funct7/funct3
//  into an extended 5-bit ALU control code (RV32I R/I ops plus RV32M) and executes the op.
//  Single-cycle ops complete in 1 cycle; MUL/DIV/REM run on an iterative XLEN-cycle engine.
//  Sits between the main decoder and writeback; valid/ready handshake on both sides.
// PARAMETERS
//  XLEN     32  operand/result width (power of 2, >=8)
//  SHAMT_W  5   shift-amount width, = log2(XLEN)
// PORTS
//  clk        in   1     clock, all state on rising edge
//  reset      in   1     synchronous, active-high reset
//  in_valid   in   1     request valid
//  in_ready   out  1     block can accept a request
//  alu_op     in   2     00 ld/st, 01 branch, 10 R-type, 11 I-type
//  funct7     in   7     instr[31:25]
//  funct3     in   3     instr[14:12]
//  op_a       in   XLEN  rs1 operand
//  op_b       in   XLEN  rs2 or immediate operand
//  out_valid  out  1     result valid
//  out_ready  in   1     consumer accepts result
//  result     out  XLEN  operation result
//  alu_ctrl   out  5     decoded control code of the held result
//  illegal    out  1     held op was an undecodable encoding
//  busy       out  1     iterative engine active
// BEHAVIOUR
//  Reset: state IDLE; in_ready=1; out_valid=0; result=0; alu_ctrl=0; illegal=0; busy=0.
//  Decode (ctrl): alu_op 00 -> ADD 00010; 01 -> SUB 00110 (funct fields ignored).
//   10, funct7=0000000: f3 000 ADD, 001 SLL 00100, 010 SLT 01000, 011 SLTU 01001,
//    100 XOR 00011, 101 SRL 00101, 110 OR 00001, 111 AND 00000.
//   10, funct7=0100000: f3 000 SUB, 101 SRA 00111; other f3 illegal.
//   10, funct7=0000001: f3 000..111 -> MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU = 10000..10111.
//   11: as funct7=0000000 row, except f3=000 ADD always; f3=101 SRA if funct7=0100000,
//    SRL if 0000000, else illegal; f3=001 requires funct7=0000000.
//   Illegal: ctrl=00000 (AND), illegal=1, result=op_a & op_b, still 1-cycle.
//  Handshake: accept when in_valid && in_ready. in_ready=1 only in IDLE.
//   out_valid, result, alu_ctrl, illegal held stable until out_valid && out_ready.
//  FSM: IDLE --accept, ctrl[4]=0--> DONE (result registered; out_valid next cycle).
//       IDLE --accept, ctrl[4]=1--> CALC (busy=1, counter=0).
//       CALC: one bit per cycle, counter 0..XLEN-1; at XLEN-1 -> DONE.
//       DONE --out_ready--> IDLE (in_ready rises the following cycle; no same-cycle re-accept).
//  Latency accept->out_valid: 1 cycle for ALU ops; XLEN+1 cycles for M ops.
//  Arithmetic: all mod 2^XLEN; shifts use op_b[SHAMT_W-1:0]; SRA sign-fills;
//   SLT signed, SLTU unsigned, result 0/1 zero-extended.
//   MUL low XLEN bits of product; MULH s*s, MULHSU s*u, MULHU u*u high XLEN bits
//   (2*XLEN-bit shift-add on magnitudes, sign fixed at end).
//   DIV/REM restoring on magnitudes; quotient sign = sa^sb, remainder sign = sign(op_a).
//  Corner cases (RISC-V spec): divide by 0 -> DIV/DIVU = all ones, REM/REMU = op_a;
//   DIV overflow (-2^(XLEN-1) / -1) -> quotient = op_a, REM = 0. Engine still runs
//   full XLEN cycles (fixed latency).
//  Operands and ctrl latched at accept; input changes afterwards are ignored.
//  reset mid-CALC or in DONE: aborts op, returns to reset state next edge, result dropped.
// TESTING
//  R-type ADD 0x7FFFFFFF+1 -> out_valid 1 cycle after accept, result 0x80000000, ctrl 00010.
//  SRA op_a=0x80000000, op_b=0x24 (shamt 4) -> 0xF8000000; SRL -> 0x08000000.
//  MULH 0xFFFFFFFF*0xFFFFFFFF -> 0; MULHU same -> 0xFFFFFFFE; out_valid at cycle 33.
//  DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; DIVU x/0 -> 0xFFFFFFFF; REMU 7/0 -> 7.
//  Back-pressure: out_ready=0 for 5 cycles -> result stable, in_ready=0; new in_valid ignored.
//  reset asserted at CALC cycle 10 -> next cycle out_valid=0, busy=0, in_ready=1; illegal
//   funct7=0100000 f3=111 R-type -> illegal=1, ctrl=00000, result=op_a&op_b.

Source files
------------

// File: rtl/alu_ctrl_mdu.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | alu_ctrl_mdu: RV32 ALU-control decode + execute with iterative MUL/DIV  |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module alu_ctrl_mdu #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      alu_ctrl,
  output logic            illegal,
  output logic            busy
);

  localparam logic [4:0] C_AND  = 5'b00000;
  localparam logic [4:0] C_OR   = 5'b00001;
  localparam logic [4:0] C_ADD  = 5'b00010;
  localparam logic [4:0] C_XOR  = 5'b00011;
  localparam logic [4:0] C_SLL  = 5'b00100;
  localparam logic [4:0] C_SRL  = 5'b00101;
  localparam logic [4:0] C_SUB  = 5'b00110;
  localparam logic [4:0] C_SRA  = 5'b00111;
  localparam logic [4:0] C_SLT  = 5'b01000;
  localparam logic [4:0] C_SLTU = 5'b01001;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;
  localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [4:0]          dec_ctrl;
  logic                dec_ill;
  logic [XLEN-1:0]     alu_res;
  logic [SHAMT_W-1:0]  shamt;
  logic                accept;
  logic                a_signed, b_signed, neg_a_in, neg_b_in;
  logic [XLEN-1:0]     mag_a, mag_b;

  logic [4:0]          ctrl_q;
  logic                ill_q;
  logic [XLEN-1:0]     res_q;
  logic [SHAMT_W-1:0]  cnt;
  logic [2*XLEN-1:0]   acc, mcand, acc_nxt, full;
  logic [XLEN-1:0]     mpl, rem, quo, mb, a_q, quo_nxt, rem_nxt, m_res;
  logic [XLEN:0]       rem_sh, diff;
  logic                neg_a, neg_b, b_zero, last;

  function automatic logic [4:0] base_ctrl(input logic [2:0] f3);
    case (f3)
      3'b000:  return C_ADD;
      3'b001:  return C_SLL;
      3'b010:  return C_SLT;
      3'b011:  return C_SLTU;
      3'b100:  return C_XOR;
      3'b101:  return C_SRL;
      3'b110:  return C_OR;
      default: return C_AND;
    endcase
  endfunction

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_CALC);
  assign result    = res_q;
  assign alu_ctrl  = ctrl_q;
  assign illegal   = ill_q;
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == CNT_LAST);

  always_comb begin
    dec_ctrl = C_ADD;
    dec_ill  = 1'b0;
    case (alu_op)
      2'b00: dec_ctrl = C_ADD;
      2'b01: dec_ctrl = C_SUB;
      2'b10: begin
        if (funct7 == F7_BASE)                          dec_ctrl = base_ctrl(funct3);
        else if (funct7 == F7_MUL)                      dec_ctrl = {2'b10, funct3};
        else if (funct7 == F7_ALT && funct3 == 3'b000)  dec_ctrl = C_SUB;
        else if (funct7 == F7_ALT && funct3 == 3'b101)  dec_ctrl = C_SRA;
        else                                            dec_ill  = 1'b1;
      end
      default: begin
        if (funct3 == 3'b001)
          dec_ill = (funct7 != F7_BASE);
        if (funct3 == 3'b101)
          dec_ill = (funct7 != F7_BASE) && (funct7 != F7_ALT);
        dec_ctrl = (funct3 == 3'b101 && funct7 == F7_ALT) ? C_SRA : base_ctrl(funct3);
      end
    endcase
    // Undecodable encodings fall back to the AND datapath
    if (dec_ill)
      dec_ctrl = C_AND;
  end

  always_comb begin
    shamt = op_b[SHAMT_W-1:0];
    case (dec_ctrl)
      C_ADD:   alu_res = op_a + op_b;
      C_SUB:   alu_res = op_a - op_b;
      C_SLL:   alu_res = op_a << shamt;
      C_SRL:   alu_res = op_a >> shamt;
      C_SRA:   alu_res = $signed(op_a) >>> shamt;
      C_SLT:   alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      C_SLTU:  alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      C_XOR:   alu_res = op_a ^ op_b;
      C_OR:    alu_res = op_a | op_b;
      default: alu_res = op_a & op_b;
    endcase
  end

  // The engine works on magnitudes; signs are reapplied on the final step
  always_comb begin
    a_signed = !(dec_ctrl[2:0] == 3'b011 || dec_ctrl[2:0] == 3'b101 || dec_ctrl[2:0] == 3'b111);
    b_signed = a_signed && (dec_ctrl[2:0] != 3'b010);
    neg_a_in = a_signed && op_a[XLEN-1];
    neg_b_in = b_signed && op_b[XLEN-1];
    mag_a    = neg_a_in ? -op_a : op_a;
    mag_b    = neg_b_in ? -op_b : op_b;
  end

  always_comb begin
    acc_nxt = mpl[0] ? (acc + mcand) : acc;
    rem_sh  = {rem, quo[XLEN-1]};
    diff    = rem_sh - {1'b0, mb};
    if (!diff[XLEN]) begin
      rem_nxt = diff[XLEN-1:0];
      quo_nxt = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_nxt = rem_sh[XLEN-1:0];
      quo_nxt = {quo[XLEN-2:0], 1'b0};
    end
    full = (neg_a ^ neg_b) ? -acc_nxt : acc_nxt;
    case (ctrl_q[2:0])
      3'b000:         m_res = full[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:         m_res = full[2*XLEN-1:XLEN];
      3'b100, 3'b101: m_res = b_zero ? {XLEN{1'b1}} : ((neg_a ^ neg_b) ? -quo_nxt : quo_nxt);
      default:        m_res = b_zero ? a_q : (neg_a ? -rem_nxt : rem_nxt);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept)    state_nxt = dec_ctrl[4] ? S_CALC : S_DONE;
      S_CALC:  if (last)      state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= 5'b0;
      ill_q  <= 1'b0;
      res_q  <= '0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mpl    <= '0;
      rem    <= '0;
      quo    <= '0;
      mb     <= '0;
      a_q    <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      b_zero <= 1'b0;
    end else if (accept) begin
      ctrl_q <= dec_ctrl;
      ill_q  <= dec_ill;
      res_q  <= alu_res;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= {{XLEN{1'b0}}, mag_a};
      mpl    <= mag_b;
      rem    <= '0;
      quo    <= mag_a;
      mb     <= mag_b;
      a_q    <= op_a;
      neg_a  <= neg_a_in;
      neg_b  <= neg_b_in;
      b_zero <= (op_b == '0);
    end else if (state == S_CALC) begin
      cnt   <= cnt + 1'b1;
      acc   <= acc_nxt;
      mcand <= mcand << 1;
      mpl   <= mpl >> 1;
      rem   <= rem_nxt;
      quo   <= quo_nxt;
      if (last)
        res_q <= m_res;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_mdu.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_alu_ctrl_mdu: vector table, directed sequences and random ops        |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_alu_ctrl_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  alu_op;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  alu_ctrl;
  logic        illegal;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  alu_ctrl_mdu #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct7(funct7), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .alu_ctrl(alu_ctrl), .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  op;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  ctrl;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: RISC-V semantics expressed with 64-bit arithmetic and SV division
  function automatic void model(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [4:0] c, output logic il, output logic [31:0] r);
    logic signed [63:0] sa, sb, p;
    logic [63:0] up;
    logic [4:0] codes [8];
    codes = '{5'b00010, 5'b00100, 5'b01000, 5'b01001, 5'b00011, 5'b00101, 5'b00001, 5'b00000};
    il = 1'b0;
    c  = 5'b00010;
    if (op == 2'd1) c = 5'b00110;
    else if (op == 2'd2) begin
      if (f7 == 7'h00) c = codes[f3];
      else if (f7 == 7'h01) c = {2'b10, f3};
      else if (f7 == 7'h20 && f3 == 3'd0) c = 5'b00110;
      else if (f7 == 7'h20 && f3 == 3'd5) c = 5'b00111;
      else il = 1'b1;
    end else if (op == 2'd3) begin
      if (f3 == 3'd1 && f7 != 7'h00) il = 1'b1;
      else if (f3 == 3'd5 && f7 == 7'h20) c = 5'b00111;
      else if (f3 == 3'd5 && f7 != 7'h00) il = 1'b1;
      else c = codes[f3];
    end
    if (il) c = 5'b00000;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (c)
      5'b00010: r = a + b;
      5'b00110: r = a - b;
      5'b00100: r = a << b[4:0];
      5'b00101: r = a >> b[4:0];
      5'b00111: r = $signed(a) >>> b[4:0];
      5'b01000: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'b01001: r = (a < b) ? 32'd1 : 32'd0;
      5'b00011: r = a ^ b;
      5'b00001: r = a | b;
      5'b00000: r = a & b;
      5'b10000: begin p = sa * sb; r = p[31:0]; end
      5'b10001: begin p = sa * sb; r = p[63:32]; end
      5'b10010: begin p = sa * $signed({32'b0, b}); r = p[63:32]; end
      5'b10011: begin up = {32'b0, a} * {32'b0, b}; r = up[63:32]; end
      5'b10100: r = (b == 0) ? 32'hFFFFFFFF :
                    (a == 32'h80000000 && b == 32'hFFFFFFFF) ? a : 32'($signed(a) / $signed(b));
      5'b10101: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      5'b10110: r = (b == 0) ? a :
                    (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'd0 : 32'($signed(a) % $signed(b));
      default:  r = (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic do_op(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic [4:0] c, output logic il,
                       output int lat, output logic bsy);
    int guard = 0;
    while (!in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    alu_op = op; funct7 = f7; funct3 = f3; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs after accept: the DUT must have latched them
    in_valid = 1'b0;
    alu_op = 2'($urandom); funct7 = 7'($urandom); funct3 = 3'($urandom);
    op_a = $urandom; op_b = $urandom;
    bsy = busy;
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    r = result; c = alu_ctrl; il = illegal;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_check(input string tag, input logic [1:0] op, input logic [6:0] f7,
                           input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] er, input logic [4:0] ec, input logic ei);
    logic [31:0] r; logic [4:0] c; logic il; int lat; logic bsy;
    do_op(op, f7, f3, a, b, r, c, il, lat, bsy);
    check({tag, " result"}, 64'(r), 64'(er));
    check({tag, " ctrl"}, 64'(c), 64'(ec));
    check({tag, " illegal"}, 64'(il), 64'(ei));
    check({tag, " latency"}, 64'(lat), ec[4] ? 64'd33 : 64'd1);
    check({tag, " busy"}, 64'(bsy), 64'(ec[4]));
  endtask

  initial begin
    logic [4:0]  mc;
    logic        mi;
    logic [31:0] mr, a, b;
    logic [1:0]  op;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] corners [5];

    vecs.push_back('{2'd2, 7'h00, 3'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'b00010, 1'b0});
    vecs.push_back('{2'd2, 7'h20, 3'd5, 32'h80000000, 32'h00000024, 32'hF8000000, 5'b00111, 1'b0});
    vecs.push_back('{2'd2, 7'h00, 3'd5, 32'h80000000, 32'h00000024, 32'h08000000, 5'b00101, 1'b0});
    vecs.push_back('{2'd2, 7'h01, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 5'b10001, 1'b0});
    vecs.push_back('{2'd2, 7'h01, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 5'b10011, 1'b0});
    vecs.push_back('{2'd2, 7'h01, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'b10010, 1'b0});
    vecs.push_back('{2'd2, 7'h01, 3'd0, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 5'b10000, 1'b0});
    vecs.push_back('{2'd2, 7'h01, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 5'b10100, 1'b0});
    vecs.push_back('{2'd2, 7'h01, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 5'b10110, 1'b0});
    vecs.push_back('{2'd2, 7'h01, 3'd5, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 5'b10101, 1'b0});
    vecs.push_back('{2'd2, 7'h01, 3'd7, 32'h00000007, 32'h00000000, 32'h00000007, 5'b10111, 1'b0});
    vecs.push_back('{2'd2, 7'h01, 3'd4, 32'hFFFFFF00, 32'h00000000, 32'hFFFFFFFF, 5'b10100, 1'b0});
    vecs.push_back('{2'd2, 7'h01, 3'd6, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 5'b10110, 1'b0});
    vecs.push_back('{2'd2, 7'h01, 3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 5'b10100, 1'b0});
    vecs.push_back('{2'd2, 7'h01, 3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 5'b10110, 1'b0});
    vecs.push_back('{2'd2, 7'h20, 3'd7, 32'hF0F0F0F0, 32'h3C3C3C3C, 32'h30303030, 5'b00000, 1'b1});
    vecs.push_back('{2'd2, 7'h10, 3'd0, 32'h0000000F, 32'h00000006, 32'h00000006, 5'b00000, 1'b1});
    vecs.push_back('{2'd0, 7'h7F, 3'd7, 32'h00000010, 32'h00000020, 32'h00000030, 5'b00010, 1'b0});
    vecs.push_back('{2'd1, 7'h01, 3'd4, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 5'b00110, 1'b0});
    vecs.push_back('{2'd3, 7'h20, 3'd5, 32'hFFFF0000, 32'h00000008, 32'hFFFFFF00, 5'b00111, 1'b0});
    vecs.push_back('{2'd3, 7'h20, 3'd0, 32'h00000005, 32'h00000003, 32'h00000008, 5'b00010, 1'b0});
    vecs.push_back('{2'd3, 7'h01, 3'd1, 32'h0000000F, 32'h00000005, 32'h00000005, 5'b00000, 1'b1});
    vecs.push_back('{2'd3, 7'h10, 3'd5, 32'h0000000C, 32'h0000000A, 32'h00000008, 5'b00000, 1'b1});
    vecs.push_back('{2'd2, 7'h00, 3'd2, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 5'b01000, 1'b0});
    vecs.push_back('{2'd2, 7'h00, 3'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b01001, 1'b0});

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = 2'd0; funct7 = 7'd0; funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset result", 64'(result), 64'd0);
    check("reset alu_ctrl", 64'(alu_ctrl), 64'd0);
    check("reset illegal", 64'(illegal), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    reset = 1'b0;

    foreach (vecs[i])
      run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].f7, vecs[i].f3,
                vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ctrl, vecs[i].ill);

    // Back-pressure: result held, no new accept while out_valid waits
    alu_op = 2'd2; funct7 = 7'h00; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    alu_op = 2'd1; op_a = 32'd100; op_b = 32'd1;
    for (int i = 0; i < 5; i++) begin
      check("bp out_valid", 64'(out_valid), 64'd1);
      check("bp result", 64'(result), 64'd7);
      check("bp in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp after handshake out_valid", 64'(out_valid), 64'd0);
    check("bp after handshake in_ready", 64'(in_ready), 64'd1);

    // Reset during the iterative engine aborts the operation
    alu_op = 2'd2; funct7 = 7'h01; funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort out_valid", 64'(out_valid), 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    check("abort in_ready", 64'(in_ready), 64'd1);
    check("abort result", 64'(result), 64'd0);
    repeat (40) @(posedge clk);
    #1;
    check("abort no late result", 64'(out_valid), 64'd0);

    corners = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    for (int n = 0; n < 300; n++) begin
      op = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd2;
      case ($urandom_range(0, 3))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        2:       f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      f3 = 3'($urandom);
      a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      model(op, f7, f3, a, b, mc, mi, mr);
      run_check($sformatf("rnd%0d op%0d f7=%0h f3=%0d a=%0h b=%0h", n, op, f7, f3, a, b),
                op, f7, f3, a, b, mr, mc, mi);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
